// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
//   arb_state_e : arbiter FSM state encoding
//   clog2_min1  : ceil(log2(n)), never below 1, for index/counter widths
package shared_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    // Width needed to hold 0..n-1; clamped to 1 so a single-value range still gets a bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
//   req   : request vector
//   ptr   : search start index
//   found : any request set
//   idx   : selected index (0 when nothing is requested)
module rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    int pos;

    // Walk offsets from farthest to nearest so the nearest match is written last.
    always_comb begin
        found = |req;
        idx   = '0;
        pos   = 0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % int'(N_REQ);
            for (int j = 0; j < int'(N_REQ); j++) begin
                if (req[j] && (j == pos)) begin
                    idx = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner sequencer for one shared WIDTH-bit register.
//   Clk   : clock
//   Rst   : asynchronous active-high reset
//   Req   : per-requester ownership request (level)
//   Wr    : per-requester write strobe, only the owner's bit counts in GRANT
//   Din   : per-requester write data, requester i at [i*WIDTH +: WIDTH]
//   Gnt   : registered one-hot grant
//   Owner : current owner index, stable through RELEASE
//   Busy  : high in GRANT and RELEASE
//   Q     : shared register contents
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [N_REQ-1:0]              Req,
    input  logic [N_REQ-1:0]              Wr,
    input  logic [N_REQ*WIDTH-1:0]        Din,
    output logic [N_REQ-1:0]              Gnt,
    output logic [clog2_min1(N_REQ)-1:0]  Owner,
    output logic                          Busy,
    output logic [WIDTH-1:0]              Q
);

    localparam int unsigned OW = clog2_min1(N_REQ);
    localparam int unsigned CW = clog2_min1(HOLD_MAX);

    arb_state_e       state;
    logic [CW-1:0]    hold_cnt;
    logic [OW-1:0]    rr_ptr;
    logic             pick_found;
    logic [OW-1:0]    pick_idx;
    logic             own_req_c;
    logic             own_wr_c;
    logic [WIDTH-1:0] own_din_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (OW)
    ) u_rr_pick (
        .req   (Req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Current owner's request, strobe and data slice.
    always_comb begin
        own_req_c = 1'b0;
        own_wr_c  = 1'b0;
        own_din_c = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (Owner == OW'(i)) begin
                own_req_c = Req[i];
                own_wr_c  = Wr[i];
                own_din_c = Din[i*WIDTH +: WIDTH];
            end
        end
    end

    // Arbiter FSM with the shared register; all outputs registered.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= ST_IDLE;
            Gnt      <= '0;
            Owner    <= '0;
            Busy     <= 1'b0;
            Q        <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state    <= ST_GRANT;
                        Gnt      <= N_REQ'(1) << pick_idx;
                        Owner    <= pick_idx;
                        Busy     <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // A write on the exit edge still lands.
                    if (own_wr_c) begin
                        Q <= own_din_c;
                    end
                    if (!own_req_c || (hold_cnt == CW'(HOLD_MAX - 1))) begin
                        state <= ST_RELEASE;
                        Gnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    // Start the next search just past the outgoing owner.
                    rr_ptr <= (Owner == OW'(N_REQ - 1)) ? '0 : Owner + OW'(1);
                    state  <= ST_IDLE;
                    Busy   <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    Gnt   <= '0;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int H = 4;

    logic        Clk;
    logic        Rst;
    logic [3:0]  Req, Wr;
    logic [31:0] Din;
    logic [3:0]  Gnt;
    logic [1:0]  Owner;
    logic        Busy;
    logic [7:0]  Q;

    logic [3:0]  req_h1, wr_h1;
    logic [31:0] din_h1;
    logic [3:0]  gnt_h1;
    logic [1:0]  owner_h1;
    logic        busy_h1;
    logic [7:0]  q_h1;

    int n_cmp;
    int n_fail;

    // Reference model: phase 0 = no owner, 1 = owner holds the register, 2 = turnaround.
    int          m_phase;
    int          m_owner;
    int          m_next;
    int          m_used;
    logic [7:0]  m_q;

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(H)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Wr(Wr), .Din(Din),
        .Gnt(Gnt), .Owner(Owner), .Busy(Busy), .Q(Q)
    );

    shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_MAX(1)) dut_h1 (
        .Clk(Clk), .Rst(Rst), .Req(req_h1), .Wr(wr_h1), .Din(din_h1),
        .Gnt(gnt_h1), .Owner(owner_h1), .Busy(busy_h1), .Q(q_h1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_next  = 0;
        m_used  = 0;
        m_q     = 8'h00;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d);
        case (m_phase)
            0: if (r != 4'b0000) begin
                for (int k = N - 1; k >= 0; k--)
                    if (r[(m_next + k) % N]) m_owner = (m_next + k) % N;
                m_phase = 1;
                m_used  = 1;
            end
            1: begin
                if (w[m_owner]) m_q = 8'(d >> (8 * m_owner));
                if (!r[m_owner] || m_used == H) m_phase = 2;
                else m_used++;
            end
            default: begin
                m_next  = (m_owner + 1) % N;
                m_phase = 0;
            end
        endcase
    endtask

    function automatic logic [3:0] m_gnt();
        return (m_phase == 1) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    task automatic step();
        @(posedge Clk);
        if (!Rst) model_edge(Req, Wr, Din);
        #1;
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        Req = '0; Wr = '0; Din = '0;
        req_h1 = '0; wr_h1 = '0; din_h1 = '0;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Req = '0; Wr = '0; Din = '0;
        req_h1 = '0; wr_h1 = '0; din_h1 = '0;
        #3;
        n_cmp++; if ({Gnt, Busy, Q, Owner} !== 15'd0) begin n_fail++; $display("FAIL reset_values: got gnt=%b busy=%b q=%h owner=%0d want all zero", Gnt, Busy, Q, Owner); end
        @(posedge Clk); #1;
        Rst = 1'b0;
        model_reset();
        Req = 4'b0100;
        step();
        n_cmp++; if (Gnt !== 4'b0100 || Owner !== 2'd2) begin n_fail++; $display("FAIL reset_grant2: got gnt=%b owner=%0d want 0100/2", Gnt, Owner); end
        Wr = 4'b0100; Din = 32'h005A_0000;
        step();
        Wr = 4'b0000;
        n_cmp++; if (Q !== 8'h5A) begin n_fail++; $display("FAIL reset_write5a: got q=%h want 5a", Q); end
        #3; Rst = 1'b1; #1;
        n_cmp++; if (Gnt !== 4'b0000 || Q !== 8'h00 || Busy !== 1'b0) begin n_fail++; $display("FAIL reset_async: got gnt=%b q=%h busy=%b want 0000/00/0", Gnt, Q, Busy); end
        model_reset();
        Req = 4'b1111;
        @(posedge Clk); #1;
        Rst = 1'b0;
        step();
        n_cmp++; if (Gnt !== 4'b0001 || Owner !== 2'd0) begin n_fail++; $display("FAIL reset_ptr0: got gnt=%b owner=%0d want 0001/0", Gnt, Owner); end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        logic       eb;
        apply_reset();
        Req = 4'b1111;
        for (int t = 0; t < 30; t++) begin
            step();
            eg = ((t % 6) < 4) ? 4'(1 << ((t / 6) % 4)) : 4'b0000;
            eb = ((t % 6) < 5);
            n_cmp++; if (Gnt !== eg || Busy !== eb) begin n_fail++; $display("FAIL rr_seq t=%0d: got gnt=%b busy=%b want %b/%b", t, Gnt, Busy, eg, eb); end
        end
    endtask

    task automatic test_write_ownership();
        apply_reset();
        Req = 4'b0010;
        step();
        n_cmp++; if (Gnt !== 4'b0010) begin n_fail++; $display("FAIL wr_owner1: got gnt=%b want 0010", Gnt); end
        Wr = 4'b0011; Din = 32'h0000_2211;
        step();
        n_cmp++; if (Q !== 8'h22) begin n_fail++; $display("FAIL wr_owner_slice: got q=%h want 22", Q); end
        Wr = 4'b0001; Din = 32'h0000_9977;
        step();
        n_cmp++; if (Q !== 8'h22) begin n_fail++; $display("FAIL wr_nonowner: got q=%h want 22", Q); end
        Wr = 4'b0000;
    endtask

    task automatic test_early_release();
        logic [3:0] eg [5] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0010};
        logic       eb [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        apply_reset();
        Req = 4'b1000;
        for (int t = 0; t < 5; t++) begin
            if (t == 2) Req = 4'b0000;
            if (t == 3) Req = 4'b0010;
            step();
            n_cmp++; if (Gnt !== eg[t] || Busy !== eb[t] || Gnt !== m_gnt()) begin n_fail++; $display("FAIL early_rel t=%0d: got gnt=%b busy=%b want %b/%b model %b", t, Gnt, Busy, eg[t], eb[t], m_gnt()); end
        end
    endtask

    task automatic test_single_cycle();
        apply_reset();
        Req = 4'b0100;
        step();
        n_cmp++; if (Gnt !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got gnt=%b want 0100", Gnt); end
        Req = 4'b0000; Wr = 4'b0100; Din = 32'h00C3_0000;
        step();
        Wr = 4'b0000;
        n_cmp++; if (Gnt !== 4'b0000 || Busy !== 1'b1 || Q !== 8'hC3) begin n_fail++; $display("FAIL single_release: got gnt=%b busy=%b q=%h want 0000/1/c3", Gnt, Busy, Q); end
        step();
        n_cmp++; if (Busy !== 1'b0 || Q !== 8'hC3) begin n_fail++; $display("FAIL single_idle: got busy=%b q=%h want 0/c3", Busy, Q); end
    endtask

    task automatic test_hold_one();
        logic [3:0] eg;
        logic       eb;
        apply_reset();
        req_h1 = 4'b0001;
        for (int t = 0; t < 9; t++) begin
            step();
            eg = ((t % 3) == 0) ? 4'b0001 : 4'b0000;
            eb = ((t % 3) != 2);
            n_cmp++; if (gnt_h1 !== eg || busy_h1 !== eb) begin n_fail++; $display("FAIL hold1 t=%0d: got gnt=%b busy=%b want %b/%b", t, gnt_h1, busy_h1, eg, eb); end
        end
        req_h1 = 4'b0000;
    endtask

    task automatic test_random();
        apply_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (Req[i]) begin if ($urandom_range(3) == 0) Req[i] = 1'b0; end
                else if ($urandom_range(2) == 0) Req[i] = 1'b1;
            end
            Wr  = 4'($urandom);
            Din = $urandom;
            step();
            n_cmp++; if (Gnt !== m_gnt() || Busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rand_ctl t=%0d: got gnt=%b busy=%b want %b/%b", t, Gnt, Busy, m_gnt(), (m_phase != 0)); end
            n_cmp++; if (Q !== m_q) begin n_fail++; $display("FAIL rand_q t=%0d: got q=%h want %h", t, Q, m_q); end
            if (m_phase != 0) begin
                n_cmp++; if (Owner !== 2'(m_owner)) begin n_fail++; $display("FAIL rand_owner t=%0d: got %0d want %0d", t, Owner, m_owner); end
            end
        end
        Req = '0; Wr = '0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_reset();
        test_reset();
        test_round_robin();
        test_write_ownership();
        test_early_release();
        test_single_cycle();
        test_hold_one();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit D-flip-flop register between N_REQ requesters.
- Grants exclusive write ownership to one requester at a time and caps the ownership length at HOLD_MAX cycles.
- Inserts one idle turnaround cycle between owners.
- Sits in front of the lab register datapath; downstream logic reads Q.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, shared register width in bits
HOLD_MAX, 4, maximum consecutive GRANT cycles per ownership (>=1)

Ports:
Clk  input  1  clock; all state changes on the rising edge
Rst  input  1  reset, asynchronous, active-high
Req  input  N_REQ  per-requester ownership request, level, held until done
Wr  input  N_REQ  per-requester write strobe; only the owner's bit is honoured
Din  input  N_REQ*WIDTH  per-requester write data; requester i uses bits [i*WIDTH +: WIDTH]
Gnt  output  N_REQ  one-hot grant, registered
Owner  output  clog2(N_REQ)  index of the current owner; valid while Busy=1 and held stable through RELEASE
Busy  output  1  high in the GRANT and RELEASE states
Q  output  WIDTH  shared register contents

Behaviour:
- Reset (async, Rst=1): state=IDLE, Gnt=0, Owner=0, Busy=0, Q=0, hold counter=0, rr pointer=0. Takes effect immediately, including mid-GRANT; an in-flight write is lost.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If Req!=0 at an edge, select the first set bit searching upward from the pointer, wrapping modulo N_REQ.
  - Next state GRANT; Gnt[sel]=1, Owner=sel, counter=0.
  - If Req==0, stay in IDLE.
- Request-to-grant latency: Req sampled at edge k, Gnt visible after edge k. A requester whose Req is already high in IDLE is granted on the next edge.
- GRANT:
  - At each edge, if Wr[Owner]=1, then Q <= Din slice of Owner at that same edge. Write latency is one edge.
  - Wr bits of non-owners are ignored in all states. Writes are also ignored in IDLE and RELEASE.
  - Exit condition at an edge: Req[Owner]=0 OR counter==HOLD_MAX-1. On exit go to RELEASE and set Gnt=0; otherwise counter++.
  - A write sampled on the exit edge still takes effect.
  - Maximum GRANT duration is HOLD_MAX cycles.
- RELEASE:
  - Lasts exactly one cycle with Gnt=0 and Busy=1.
  - Pointer <= (Owner+1) mod N_REQ, then go to IDLE.
  - New requests are not evaluated in RELEASE.
- Fairness: after a forced release (hold limit reached), the same requester is served again only after every other active requester has had a turn.
- Simultaneous requests: pointer order decides; no fixed priority.
- Single requester held high continuously: GRANT HOLD_MAX cycles, RELEASE 1, IDLE 1, GRANT again. Period is HOLD_MAX+2.
- Requester drops Req in the same cycle it is granted: it gets exactly 1 GRANT cycle, and its Wr in that cycle is honoured.
- Pointer wrap: index N_REQ-1 is followed by index 0.
- Gnt is never multi-hot. Gnt is nonzero only in GRANT.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - a log2 helper function/constant for the Owner and counter widths.
- One sub-module is natural: rr_pick.
  - Purely combinational: inputs Req and pointer; outputs a found flag and the index.
  - It is reused by other arbiters in the labs.
- The register bank stays inline in this block.

Test Plan:
- Reset mid-GRANT: owner 2 granted with Q=8'h5A, assert Rst between edges -> Gnt=0, Q=0, Busy=0 immediately. After release, Req=4'b1111 -> requester 0 is granted first.
- Round-robin with all requesting: Req=4'b1111 held, HOLD_MAX=4 -> Gnt sequence 0001,1000-free gap, 0010, 0100, 1000, 0001. Each GRANT is 4 cycles, separated by 1 RELEASE + 1 IDLE cycle.
- Write ownership: owner 1 with Wr=4'b0011, Din slice0=8'h11, slice1=8'h22 -> Q=8'h22 after the edge. Wr[0] alone during owner 1 -> Q unchanged.
- Early release: requester 3 granted, drops Req after 2 cycles -> GRANT lasts 2 cycles, then RELEASE, then pointer=0. Only requester 1 pending -> requester 1 is granted 2 edges later.
- Single-cycle request: Req[2] pulses 1 cycle with Wr[2]=1 in its grant cycle, Din=8'hC3 -> exactly 1 GRANT cycle and Q=8'hC3.
- Hold limit with HOLD_MAX=1: Req=4'b0001 constant -> Gnt pattern 1,0,0 repeating. Busy pattern 1,1,0.
